// File: rtl/fir_decim_mac.sv
// Run-time programmable decimating FIR: circular sample RAM, one pipelined MAC,
// round/shift/saturate output stage and a side port for loading coefficients.
module fir_decim_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int NUM_TAPS   = 199,
    parameter int RATE       = 8,
    parameter int OUT_SHIFT  = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] ast_sink_data,
    input  logic                         ast_sink_valid,
    input  logic [1:0]                   ast_sink_error,
    output logic signed [DATA_WIDTH-1:0] ast_source_data,
    output logic                         ast_source_valid,
    output logic [1:0]                   ast_source_error,
    input  logic                         coef_wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0]  coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_wr_data,
    output logic                         coef_ready,
    output logic                         overrun
);

    localparam int AW    = $clog2(NUM_TAPS);
    localparam int CW    = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int PW    = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_TAPS);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_TAPS - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(RATE - 1);
    localparam logic [AW:0]   TAPS_EXT  = (AW + 1)'(NUM_TAPS);

    localparam logic signed [ACC_W:0] ONE_X = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] RND   = (ONE_X << OUT_SHIFT) >> 1;
    localparam logic signed [ACC_W:0] MAXV  = (ONE_X << (DATA_WIDTH - 1)) - ONE_X;
    localparam logic signed [ACC_W:0] MINV  = -(ONE_X << (DATA_WIDTH - 1));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic signed [DATA_WIDTH-1:0] r_samp_mem [0:NUM_TAPS-1];
    logic signed [COEF_WIDTH-1:0] r_coef_mem [0:NUM_TAPS-1];

    logic [AW-1:0]                r_waddr;
    logic [AW-1:0]                w_waddr_nxt;
    logic [CW-1:0]                r_deci_cnt;
    logic                         r_err_acc;
    logic                         w_err_now;
    logic                         r_win_err;
    logic [AW-1:0]                r_base;
    logic [AW-1:0]                r_tap;
    logic [1:0]                   r_flush_cnt;
    logic [AW:0]                  w_rd_sum;
    logic [AW-1:0]                w_rd_addr;
    logic [AW-1:0]                w_coef_raddr;
    logic signed [DATA_WIDTH-1:0] r_samp_q;
    logic signed [COEF_WIDTH-1:0] r_coef_q;
    logic                         r_rd_vld;
    logic signed [PW-1:0]         r_prod;
    logic                         r_prod_vld;
    logic signed [ACC_W-1:0]      r_acc;
    logic                         r_pending_ovr;
    logic                         r_overrun;
    logic                         r_coef_ready;
    logic signed [DATA_WIDTH-1:0] r_src_data;
    logic                         r_src_valid;
    logic [1:0]                   r_src_err;

    logic w_trig;
    logic w_accept;
    logic w_drop;
    logic w_emit;
    logic w_addr_ok;
    logic w_coef_we;

    // Round half up, arithmetic shift, then clamp into the output sample range.
    function automatic logic signed [DATA_WIDTH-1:0] f_round_sat(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W:0] v_sum;
        logic signed [DATA_WIDTH-1:0] v_res;
        v_sum = (ACC_W + 1)'(acc) + RND;
        v_sum = v_sum >>> OUT_SHIFT;
        if (v_sum > MAXV) begin
            v_res = DATA_WIDTH'(MAXV);
        end else if (v_sum < MINV) begin
            v_res = DATA_WIDTH'(MINV);
        end else begin
            v_res = DATA_WIDTH'(v_sum);
        end
        return v_res;
    endfunction

    generate
        if ((1 << AW) == NUM_TAPS) begin : g_addr_full
            assign w_addr_ok = 1'b1;
        end else begin : g_addr_part
            assign w_addr_ok = (coef_addr <= LAST_ADDR);
        end
    endgenerate

    assign w_trig    = ast_sink_valid && (r_deci_cnt == LAST_CNT);
    assign w_accept  = w_trig && ((r_state == S_IDLE) || (r_state == S_OUT));
    assign w_drop    = w_trig && !w_accept;
    assign w_coef_we = coef_wr_en && r_coef_ready && w_addr_ok;

    // Address arithmetic: write pointer wrap, oldest-first read pointer, reversed tap index.
    always_comb begin
        w_waddr_nxt  = r_waddr;
        w_rd_sum     = {1'b0, r_base} + {1'b0, r_tap};
        w_rd_addr    = AW'(w_rd_sum);
        w_coef_raddr = LAST_ADDR - r_tap;
        w_err_now    = |ast_sink_error;
        if (r_waddr == LAST_ADDR) begin
            w_waddr_nxt = '0;
        end else begin
            w_waddr_nxt = r_waddr + AW'(1'b1);
        end
        if (w_rd_sum >= TAPS_EXT) begin
            w_rd_addr = AW'(w_rd_sum - TAPS_EXT);
        end else begin
            w_rd_addr = AW'(w_rd_sum);
        end
        if (r_deci_cnt == '0) begin
            w_err_now = |ast_sink_error;
        end else begin
            w_err_now = r_err_acc | (|ast_sink_error);
        end
    end

    // Next-state logic for the MAC sequencer.
    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_tap == LAST_ADDR) begin
                    w_next_state = S_FLUSH;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == 2'd2) begin
                    w_next_state = S_OUT;
                    w_emit       = 1'b1;
                end else begin
                    w_next_state = S_FLUSH;
                end
            end
            S_OUT: begin
                if (w_trig) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Sample RAM: one write and one registered read per clock, read returns old data.
    always_ff @(posedge clk) begin
        if (ast_sink_valid) begin
            r_samp_mem[r_waddr] <= ast_sink_data;
        end
        r_samp_q <= r_samp_mem[w_rd_addr];
    end

    // Coefficient RAM: writes only land while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (w_coef_we) begin
            r_coef_mem[coef_addr] <= coef_wr_data;
        end
        r_coef_q <= r_coef_mem[w_coef_raddr];
    end

    // Write side: pointer, decimation phase and error window; never stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_waddr    <= '0;
            r_deci_cnt <= '0;
            r_err_acc  <= 1'b0;
        end else if (ast_sink_valid) begin
            r_waddr   <= w_waddr_nxt;
            r_err_acc <= w_err_now;
            if (r_deci_cnt == LAST_CNT) begin
                r_deci_cnt <= '0;
            end else begin
                r_deci_cnt <= r_deci_cnt + CW'(1'b1);
            end
        end
    end

    // Sequencer state, tap/flush counters and window latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_tap        <= '0;
            r_flush_cnt  <= 2'd0;
            r_win_err    <= 1'b0;
            r_coef_ready <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_coef_ready <= (w_next_state == S_IDLE);
            if (w_accept) begin
                r_base    <= w_waddr_nxt;
                r_tap     <= '0;
                r_win_err <= w_err_now;
            end else if (r_state == S_RUN) begin
                r_tap <= r_tap + AW'(1'b1);
            end
            if (r_state == S_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + 2'd1;
            end else begin
                r_flush_cnt <= 2'd0;
            end
        end
    end

    // MAC pipeline: RAM read, product register, accumulate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_vld   <= 1'b0;
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_rd_vld   <= (r_state == S_RUN);
            r_prod     <= r_samp_q * r_coef_q;
            r_prod_vld <= r_rd_vld;
            if (w_accept) begin
                r_acc <= '0;
            end else if (r_prod_vld) begin
                r_acc <= r_acc + ACC_W'(r_prod);
            end
        end
    end

    // Output register, overrun tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src_data    <= '0;
            r_src_valid   <= 1'b0;
            r_src_err     <= 2'b00;
            r_pending_ovr <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_src_valid <= w_emit;
            if (w_emit) begin
                r_src_data <= f_round_sat(r_acc);
                r_src_err  <= {r_pending_ovr, r_win_err};
            end
            if (w_drop) begin
                r_pending_ovr <= 1'b1;
                r_overrun     <= 1'b1;
            end else if (w_emit) begin
                r_pending_ovr <= 1'b0;
            end
        end
    end

    assign ast_source_data  = r_src_data;
    assign ast_source_valid = r_src_valid;
    assign ast_source_error = r_src_err;
    assign coef_ready       = r_coef_ready;
    assign overrun          = r_overrun;

endmodule

// File: tb/tb_fir_decim_mac.sv
// Directed bench for fir_decim_mac: two instances (OUT_SHIFT 0 and 8) share stimulus.
module tb_fir_decim_mac;

    logic clk;
    logic reset;
    logic signed [15:0] sink_data;
    logic sink_valid;
    logic [1:0] sink_err;
    logic coef_wr_en;
    logic [2:0] coef_addr;
    logic signed [15:0] coef_data;

    logic signed [15:0] src_data0, src_data1;
    logic src_valid0, src_valid1;
    logic [1:0] src_err0, src_err1;
    logic coef_ready0, coef_ready1;
    logic overrun0, overrun1;

    int cyc = 0;
    int t_send = 0;
    int n_pass = 0;
    int n_total = 0;

    logic signed [15:0] q0_data[$];
    logic [1:0] q0_err[$];
    int q0_time[$];
    logic signed [15:0] q1_data[$];

    fir_decim_mac #(.DATA_WIDTH(16), .COEF_WIDTH(16), .NUM_TAPS(8), .RATE(2), .OUT_SHIFT(0)) dut0 (
        .clk(clk), .reset(reset),
        .ast_sink_data(sink_data), .ast_sink_valid(sink_valid), .ast_sink_error(sink_err),
        .ast_source_data(src_data0), .ast_source_valid(src_valid0), .ast_source_error(src_err0),
        .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_wr_data(coef_data),
        .coef_ready(coef_ready0), .overrun(overrun0)
    );

    fir_decim_mac #(.DATA_WIDTH(16), .COEF_WIDTH(16), .NUM_TAPS(8), .RATE(2), .OUT_SHIFT(8)) dut1 (
        .clk(clk), .reset(reset),
        .ast_sink_data(sink_data), .ast_sink_valid(sink_valid), .ast_sink_error(sink_err),
        .ast_source_data(src_data1), .ast_source_valid(src_valid1), .ast_source_error(src_err1),
        .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_wr_data(coef_data),
        .coef_ready(coef_ready1), .overrun(overrun1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (src_valid0) begin
            q0_data.push_back(src_data0);
            q0_err.push_back(src_err0);
            q0_time.push_back(cyc);
        end
        if (src_valid1) begin
            q1_data.push_back(src_data1);
        end
    end

    task automatic clear_q();
        q0_data.delete();
        q0_err.delete();
        q0_time.delete();
        q1_data.delete();
    endtask

    task automatic send(input logic signed [15:0] d, input logic [1:0] e, input int gap);
        sink_data = d;
        sink_valid = 1'b1;
        sink_err = e;
        t_send = cyc;
        @(negedge clk);
        sink_valid = 1'b0;
        sink_err = 2'b00;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic wr_coef(input logic [2:0] a, input logic signed [15:0] v);
        coef_wr_en = 1'b1;
        coef_addr = a;
        coef_data = v;
        @(negedge clk);
        coef_wr_en = 1'b0;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 8; k++) wr_coef(3'(k), 16'(k + 1));
    endtask

    task automatic load_const(input logic signed [15:0] v);
        for (int k = 0; k < 8; k++) wr_coef(3'(k), v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (src_data0 !== 16'sd0) $display("FAIL reset_data got %0d exp 0", src_data0); else n_pass++;
        n_total++; if (src_valid0 !== 1'b0) $display("FAIL reset_valid got %b exp 0", src_valid0); else n_pass++;
        n_total++; if (src_err0 !== 2'b00) $display("FAIL reset_err got %b exp 00", src_err0); else n_pass++;
        n_total++; if (overrun0 !== 1'b0) $display("FAIL reset_overrun got %b exp 0", overrun0); else n_pass++;
        n_total++; if (coef_ready0 !== 1'b1) $display("FAIL reset_coef_ready got %b exp 1", coef_ready0); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_impulse();
        logic signed [15:0] exp_imp [0:4];
        exp_imp = '{16'sd2, 16'sd4, 16'sd6, 16'sd8, 16'sd0};
        do_reset();
        load_ramp();
        for (int i = 0; i < 20; i++) begin
            clear_q();
            send((i == 10) ? 16'sd1 : 16'sd0, 2'b00, 20);
            if (i >= 11 && (i % 2) == 1) begin
                n_total++; if (q0_data.size() != 1) $display("FAIL impulse_count i=%0d got %0d exp 1", i, q0_data.size()); else n_pass++;
                if (q0_data.size() > 0) begin
                    n_total++; if (q0_data[0] !== exp_imp[(i - 11) / 2]) $display("FAIL impulse_data i=%0d got %0d exp %0d", i, q0_data[0], exp_imp[(i - 11) / 2]); else n_pass++;
                    n_total++; if (q0_time[0] - t_send != 12) $display("FAIL impulse_latency i=%0d got %0d exp 12", i, q0_time[0] - t_send); else n_pass++;
                    n_total++; if (q0_err[0] !== 2'b00) $display("FAIL impulse_err i=%0d got %b exp 00", i, q0_err[0]); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_gain();
        do_reset();
        load_const(16'sd1000);
        for (int i = 0; i < 10; i++) begin
            clear_q();
            send(16'sd1000, 2'b00, 20);
            if (i == 7 || i == 9) begin
                n_total++; if (q1_data.size() != 1) $display("FAIL gain_count i=%0d got %0d exp 1", i, q1_data.size()); else n_pass++;
                if (q1_data.size() > 0 && q0_data.size() > 0) begin
                    n_total++; if (q1_data[0] !== 16'sd31250) $display("FAIL gain_shift8 i=%0d got %0d exp 31250", i, q1_data[0]); else n_pass++;
                    n_total++; if (q0_data[0] !== 16'sd32767) $display("FAIL gain_shift0_sat i=%0d got %0d exp 32767", i, q0_data[0]); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_saturation();
        load_const(16'sd32767);
        for (int i = 0; i < 10; i++) begin
            clear_q();
            send(16'sd32767, 2'b00, 20);
        end
        n_total++; if (q1_data.size() != 1 || q1_data[0] !== 16'sd32767) $display("FAIL sat_pos got %0d exp 32767", (q1_data.size() > 0) ? q1_data[0] : 16'sd0); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            clear_q();
            send(16'sh8000, 2'b00, 20);
        end
        n_total++; if (q1_data.size() != 1 || q1_data[0] !== 16'sh8000) $display("FAIL sat_neg got %0d exp -32768", (q1_data.size() > 0) ? q1_data[0] : 16'sd0); else n_pass++;
        n_total++; if (q0_data.size() != 1 || q0_data[0] !== 16'sh8000) $display("FAIL sat_neg_shift0 got %0d exp -32768", (q0_data.size() > 0) ? q0_data[0] : 16'sd0); else n_pass++;
    endtask

    task automatic test_coef_guard();
        load_ramp();
        for (int i = 0; i < 9; i++) send(16'sd0, 2'b00, 20);
        clear_q();
        send(16'sd1, 2'b00, 4);
        n_total++; if (coef_ready0 !== 1'b0) $display("FAIL guard_ready_busy got %b exp 0", coef_ready0); else n_pass++;
        wr_coef(3'd0, 16'sd99);
        repeat (15) @(negedge clk);
        n_total++; if (q0_data.size() != 1 || q0_data[0] !== 16'sd1) $display("FAIL guard_h0_kept got %0d exp 1", (q0_data.size() > 0) ? q0_data[0] : 16'sd0); else n_pass++;
        n_total++; if (coef_ready0 !== 1'b1) $display("FAIL guard_ready_idle got %b exp 1", coef_ready0); else n_pass++;
        send(16'sd0, 2'b00, 20);
        clear_q();
        coef_wr_en = 1'b1;
        coef_addr = 3'd0;
        coef_data = 16'sd99;
        sink_data = 16'sd1;
        sink_valid = 1'b1;
        t_send = cyc;
        @(negedge clk);
        coef_wr_en = 1'b0;
        sink_valid = 1'b0;
        repeat (19) @(negedge clk);
        n_total++; if (q0_data.size() != 1 || q0_data[0] !== 16'sd102) $display("FAIL guard_same_cycle_write got %0d exp 102", (q0_data.size() > 0) ? q0_data[0] : 16'sd0); else n_pass++;
    endtask

    task automatic test_error();
        logic [1:0] errs [0:5];
        logic [1:0] exp_e [0:2];
        errs = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        exp_e = '{2'b00, 2'b01, 2'b00};
        do_reset();
        n_total++; if (overrun0 !== 1'b0) $display("FAIL error_overrun_clear got %b exp 0", overrun0); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            clear_q();
            send(16'sd0, errs[i], 20);
            if ((i % 2) == 1) begin
                n_total++; if (q0_err.size() != 1 || q0_err[0] !== exp_e[i / 2]) $display("FAIL error_window i=%0d got %b exp %b", i, (q0_err.size() > 0) ? q0_err[0] : 2'bxx, exp_e[i / 2]); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int t_first;
        t_first = 0;
        do_reset();
        wr_coef(3'd0, 16'sd1);
        for (int i = 0; i < 8; i++) send(16'sd0, 2'b00, 20);
        clear_q();
        for (int j = 0; j < 16; j++) begin
            send(16'(j + 1), 2'b00, 1);
            if (j == 1) t_first = t_send;
        end
        repeat (30) @(negedge clk);
        n_total++; if (overrun0 !== 1'b1) $display("FAIL b2b_overrun got %b exp 1", overrun0); else n_pass++;
        n_total++; if (q0_data.size() != 2) $display("FAIL b2b_count got %0d exp 2", q0_data.size()); else n_pass++;
        if (q0_data.size() >= 2) begin
            n_total++; if (q0_data[0] !== 16'sd4) $display("FAIL b2b_data0 got %0d exp 4", q0_data[0]); else n_pass++;
            n_total++; if (q0_err[0] !== 2'b10) $display("FAIL b2b_err0 got %b exp 10", q0_err[0]); else n_pass++;
            n_total++; if (q0_time[0] - t_first != 12) $display("FAIL b2b_time0 got %0d exp 12", q0_time[0] - t_first); else n_pass++;
            n_total++; if (q0_data[1] !== 16'sd336) $display("FAIL b2b_data1 got %0d exp 336", q0_data[1]); else n_pass++;
            n_total++; if (q0_err[1] !== 2'b10) $display("FAIL b2b_err1 got %b exp 10", q0_err[1]); else n_pass++;
            n_total++; if (q0_time[1] - t_first != 24) $display("FAIL b2b_time1 got %0d exp 24", q0_time[1] - t_first); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run();
        clear_q();
        send(16'sd0, 2'b00, 1);
        send(16'sd5, 2'b00, 5);
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (src_data0 !== 16'sd0) $display("FAIL midrst_data got %0d exp 0", src_data0); else n_pass++;
        n_total++; if (src_valid0 !== 1'b0) $display("FAIL midrst_valid got %b exp 0", src_valid0); else n_pass++;
        n_total++; if (overrun0 !== 1'b0) $display("FAIL midrst_overrun got %b exp 0", overrun0); else n_pass++;
        n_total++; if (coef_ready0 !== 1'b1) $display("FAIL midrst_coef_ready got %b exp 1", coef_ready0); else n_pass++;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        n_total++; if (q0_data.size() != 0) $display("FAIL midrst_no_strobe got %0d exp 0", q0_data.size()); else n_pass++;
        send(16'sd7, 2'b00, 20);
        n_total++; if (q0_data.size() != 0) $display("FAIL midrst_first_sample got %0d strobes exp 0", q0_data.size()); else n_pass++;
        send(16'sd7, 2'b00, 20);
        n_total++; if (q0_data.size() != 1) $display("FAIL midrst_second_sample got %0d strobes exp 1", q0_data.size()); else n_pass++;
        if (q0_time.size() > 0) begin
            n_total++; if (q0_time[0] - t_send != 12) $display("FAIL midrst_latency got %0d exp 12", q0_time[0] - t_send); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        sink_data = 16'sd0;
        sink_valid = 1'b0;
        sink_err = 2'b00;
        coef_wr_en = 1'b0;
        coef_addr = 3'd0;
        coef_data = 16'sd0;
        @(negedge clk);
        test_reset();
        test_impulse();
        test_gain();
        test_saturation();
        test_coef_guard();
        test_error();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
